// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: exception codes, default PCs and exception code width.
package pipe_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall hold, bubble flush, exception
// flush to the handler PC, oldest-exception merge and bubble/stall counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W     = 128,
  parameter int          EXC_W      = pipe_pkg::EXC_W,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              stall,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       pc4_in,
  input  logic [31:0]       pc8_in,
  input  logic [EXC_W-1:0]  exc_old_in,
  input  logic [EXC_W-1:0]  exc_new_in,
  input  logic              bd_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [31:0]       pc4_out,
  output logic [31:0]       pc8_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              bd_out,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [EXC_W-1:0]  EXC_ZERO = {EXC_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // An exception raised in an earlier stage is older and therefore takes precedence.
  function automatic logic [EXC_W-1:0] oldest_exc(input logic [EXC_W-1:0] exc_old,
                                                  input logic [EXC_W-1:0] exc_new);
    if (exc_old != EXC_ZERO) begin
      return exc_old;
    end else begin
      return exc_new;
    end
  endfunction

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [31:0]       pc4_q,    pc4_d;
  logic [31:0]       pc8_q,    pc8_d;
  logic [EXC_W-1:0]  exc_q,    exc_d;
  logic              bd_q,     bd_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  stall_q,  stall_d;

  // Next-state selection in priority order req > flush > stall > load.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    pc4_d    = pc4_q;
    pc8_d    = pc8_q;
    exc_d    = exc_q;
    bd_d     = bd_q;
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (req) begin
      valid_d = 1'b0;
      data_d  = DATA_ZERO;
      exc_d   = EXC_ZERO;
      bd_d    = 1'b0;
      pc4_d   = HANDLER_PC + 32'd4;
      pc8_d   = HANDLER_PC + 32'd8;
    end else if (flush) begin
      // The bubble keeps its PCs so a later EPC computed from it stays meaningful.
      valid_d  = 1'b0;
      data_d   = DATA_ZERO;
      exc_d    = EXC_ZERO;
      bd_d     = 1'b0;
      pc4_d    = pc4_in;
      pc8_d    = pc8_in;
      bubble_d = bubble_q + CNT_ONE;
    end else if (stall) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      pc4_d = pc4_in;
      pc8_d = pc8_in;
      if (valid_in) begin
        valid_d = 1'b1;
        data_d  = data_in;
        exc_d   = oldest_exc(exc_old_in, exc_new_in);
        bd_d    = bd_in;
      end else begin
        valid_d  = 1'b0;
        data_d   = DATA_ZERO;
        exc_d    = EXC_ZERO;
        bd_d     = 1'b0;
        bubble_d = bubble_q + CNT_ONE;
      end
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= DATA_ZERO;
      pc4_q    <= RESET_PC + 32'd4;
      pc8_q    <= RESET_PC + 32'd8;
      exc_q    <= EXC_ZERO;
      bd_q     <= 1'b0;
      bubble_q <= CNT_ZERO;
      stall_q  <= CNT_ZERO;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      pc4_q    <= pc4_d;
      pc8_q    <= pc8_d;
      exc_q    <= exc_d;
      bd_q     <= bd_d;
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign pc4_out    = pc4_q;
  assign pc8_out    = pc8_q;
  assign exc_out    = exc_q;
  assign bd_out     = bd_q;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with a 4-bit counter covers wrap-around.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset, req, flush, stall, valid_in, bd_in;
  logic [127:0] data_in;
  logic [31:0]  pc4_in, pc8_in;
  logic [4:0]   exc_old_in, exc_new_in;

  logic         valid_out, bd_out;
  logic [127:0] data_out;
  logic [31:0]  pc4_out, pc8_out;
  logic [4:0]   exc_out;
  logic [31:0]  bubble_cnt, stall_cnt;

  logic         s_valid_out, s_bd_out;
  logic [127:0] s_data_out;
  logic [31:0]  s_pc4_out, s_pc8_out;
  logic [4:0]   s_exc_out;
  logic [3:0]   s_bubble_cnt, s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] PAT_A = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] PAT_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
    .valid_in(valid_in), .data_in(data_in), .pc4_in(pc4_in), .pc8_in(pc8_in),
    .exc_old_in(exc_old_in), .exc_new_in(exc_new_in), .bd_in(bd_in),
    .valid_out(valid_out), .data_out(data_out), .pc4_out(pc4_out), .pc8_out(pc8_out),
    .exc_out(exc_out), .bd_out(bd_out), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
    .valid_in(valid_in), .data_in(data_in), .pc4_in(pc4_in), .pc8_in(pc8_in),
    .exc_old_in(exc_old_in), .exc_new_in(exc_new_in), .bd_in(bd_in),
    .valid_out(s_valid_out), .data_out(s_data_out), .pc4_out(s_pc4_out), .pc8_out(s_pc8_out),
    .exc_out(s_exc_out), .bd_out(s_bd_out), .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; flush = 1'b0; stall = 1'b0;
    valid_in = 1'b0; bd_in = 1'b0; data_in = '0;
    pc4_in = 32'h0; pc8_in = 32'h0; exc_old_in = 5'd0; exc_new_in = 5'd0;
    step();
    reset = 1'b0;
    check_val("rst_valid", valid_out, 1'b0);
    check_val("rst_data", data_out, 128'd0);
    check_val("rst_pc4", pc4_out, 32'h3004);
    check_val("rst_pc8", pc8_out, 32'h3008);
    check_val("rst_bub", bubble_cnt, 32'd0);
    check_val("rst_stl", stall_cnt, 32'd0);

    // Load, new exception only
    valid_in = 1'b1; data_in = PAT_A; pc4_in = 32'h3008; pc8_in = 32'h300C;
    exc_old_in = 5'd0; exc_new_in = 5'd12; bd_in = 1'b1;
    step();
    check_val("ld_valid", valid_out, 1'b1);
    check_val("ld_data", data_out, PAT_A);
    check_val("ld_exc_new", exc_out, 5'd12);
    check_val("ld_bd", bd_out, 1'b1);
    check_val("ld_pc4", pc4_out, 32'h3008);
    check_val("ld_pc8", pc8_out, 32'h300C);
    check_val("ld_bub", bubble_cnt, 32'd0);

    // Older exception wins
    exc_old_in = 5'd4; exc_new_in = 5'd12; bd_in = 1'b0; data_in = PAT_B;
    step();
    check_val("ld_exc_old", exc_out, 5'd4);
    check_val("ld_bd0", bd_out, 1'b0);
    check_val("ld_data_b", data_out, PAT_B);

    // Inputs change between edges: outputs must not follow
    data_in = PAT_A;
    #2;
    check_val("no_comb_path", data_out, PAT_B);

    // Load 0x3010 then hold for three stall edges while inputs change
    exc_old_in = 5'd0; exc_new_in = 5'd10;
    pc4_in = 32'h3010; pc8_in = 32'h3014; data_in = PAT_A;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc4_in = 32'h5000 + i; pc8_in = 32'h6000 + i; data_in = PAT_B; exc_new_in = 5'd5;
      step();
      check_val("stl_pc4", pc4_out, 32'h3010);
    end
    check_val("stl_pc8", pc8_out, 32'h3014);
    check_val("stl_data", data_out, PAT_A);
    check_val("stl_exc", exc_out, 5'd10);
    check_val("stl_cnt3", stall_cnt, 32'd3);
    check_val("stl_bub", bubble_cnt, 32'd0);

    // Flush beats stall
    flush = 1'b1; pc4_in = 32'h3020; pc8_in = 32'h3024; valid_in = 1'b1; exc_old_in = 5'd4;
    step();
    check_val("fl_valid", valid_out, 1'b0);
    check_val("fl_exc", exc_out, 5'd0);
    check_val("fl_data", data_out, 128'd0);
    check_val("fl_pc4", pc4_out, 32'h3020);
    check_val("fl_pc8", pc8_out, 32'h3024);
    check_val("fl_bub", bubble_cnt, 32'd1);
    check_val("fl_stl", stall_cnt, 32'd3);

    // Load of an invalid slot becomes a counted bubble
    flush = 1'b0; stall = 1'b0; valid_in = 1'b0; data_in = PAT_A; exc_old_in = 5'd5; bd_in = 1'b1;
    pc4_in = 32'h3030; pc8_in = 32'h3034;
    step();
    check_val("iv_valid", valid_out, 1'b0);
    check_val("iv_data", data_out, 128'd0);
    check_val("iv_exc", exc_out, 5'd0);
    check_val("iv_bd", bd_out, 1'b0);
    check_val("iv_pc4", pc4_out, 32'h3030);
    check_val("iv_bub", bubble_cnt, 32'd2);

    // Exception request beats flush and stall
    req = 1'b1; flush = 1'b1; stall = 1'b1; valid_in = 1'b1; bd_in = 1'b1;
    step();
    req = 1'b0; flush = 1'b0; stall = 1'b0;
    check_val("req_pc4", pc4_out, 32'h4184);
    check_val("req_pc8", pc8_out, 32'h4188);
    check_val("req_bd", bd_out, 1'b0);
    check_val("req_valid", valid_out, 1'b0);
    check_val("req_bub", bubble_cnt, 32'd2);
    check_val("req_stl", stall_cnt, 32'd3);

    // Reset during stall clears the stage
    valid_in = 1'b1; bd_in = 1'b0; exc_old_in = 5'd0; exc_new_in = 5'd0; pc4_in = 32'h3040; pc8_in = 32'h3044;
    step();
    check_val("pre_rst_valid", valid_out, 1'b1);
    stall = 1'b1; reset = 1'b1;
    step();
    check_val("rs_valid", valid_out, 1'b0);
    check_val("rs_pc4", pc4_out, 32'h3004);
    check_val("rs_stl", stall_cnt, 32'd0);
    check_val("rs_bub", bubble_cnt, 32'd0);

    // 17 stalls: 4-bit counter wraps to 1, 32-bit counter reads 17
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check_val("wrap_small", s_stall_cnt, 4'd1);
    check_val("wrap_big", stall_cnt, 32'd17);
    check_val("wrap_hold", s_pc4_out, 32'h3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
